// File: rtl/alu_fault_monitor.sv
// ALU fault monitor: a two-stage pipeline that counts checker errors per unit, logs fault
// records in a valid/ready FIFO and escalates OK -> FAULT -> LOCKED on sustained faults.
module alu_fault_monitor #(
    parameter int CNT_W       = 16,
    parameter int DEPTH       = 8,
    parameter int LOCK_THRESH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    input  logic             cin,
    input  logic [4:0]       ctrl_shiftamt,
    input  logic [31:0]      sum,
    input  logic [31:0]      sll_result,
    input  logic [31:0]      sra_result,
    input  logic             adder_error,
    input  logic             sll_error,
    input  logic             sra_error,
    input  logic             clear,
    input  logic             log_ready,
    output logic             log_valid,
    output logic [2:0]       log_mask,
    output logic [31:0]      log_a,
    output logic [31:0]      log_result,
    output logic [4:0]       log_shamt,
    output logic             log_overflow,
    output logic [CNT_W-1:0] add_err_cnt,
    output logic [CNT_W-1:0] sll_err_cnt,
    output logic [CNT_W-1:0] sra_err_cnt,
    output logic             fault_irq,
    output logic             alu_disable
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CON_W = $clog2(LOCK_THRESH + 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [CON_W-1:0] LOCK_CNT = CON_W'(LOCK_THRESH);

    typedef enum logic [1:0] {ST_OK, ST_FAULT, ST_LOCKED} state_t;

    typedef struct packed {
        logic [2:0]  mask;
        logic [31:0] a;
        logic [31:0] result;
        logic [4:0]  shamt;
    } rec_t;

    logic        r_s1_valid;
    logic [31:0] r_s1_a, r_s1_b, r_s1_sum, r_s1_sll, r_s1_sra;
    logic        r_s1_cin;
    logic [4:0]  r_s1_shamt;
    logic [2:0]  r_s1_mask;

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_cin   <= 1'b0;
            r_s1_shamt <= '0;
            r_s1_sum   <= '0;
            r_s1_sll   <= '0;
            r_s1_sra   <= '0;
            r_s1_mask  <= '0;
        end else begin
            r_s1_valid <= in_valid && !clear;
            if (in_valid && !clear) begin
                r_s1_a     <= a;
                r_s1_b     <= b;
                r_s1_cin   <= cin;
                r_s1_shamt <= ctrl_shiftamt;
                r_s1_sum   <= sum;
                r_s1_sll   <= sll_result;
                r_s1_sra   <= sra_result;
                r_s1_mask  <= {sra_error, sll_error, adder_error};
            end
        end
    end

    // Operand B and carry-in are captured with the sample but no record field carries them.
    logic w_unused;
    assign w_unused = ^{r_s1_b, r_s1_cin};

    logic w_fault;
    rec_t w_rec;
    assign w_fault = r_s1_valid && (r_s1_mask != 3'b000);

    // NOTE: always_comb assigns a default first so no path can infer a latch.
    always_comb begin
        w_rec       = '0;
        w_rec.mask  = r_s1_mask;
        w_rec.a     = r_s1_a;
        w_rec.shamt = r_s1_shamt;
        if (r_s1_mask[0])      w_rec.result = r_s1_sum;
        else if (r_s1_mask[1]) w_rec.result = r_s1_sll;
        else                   w_rec.result = r_s1_sra;
    end

    rec_t             r_mem [DEPTH];
    rec_t             r_head, w_head_next;
    logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr, w_rd_next;
    logic [PTR_W:0]   r_count, w_count_next, w_after_pop;
    logic             r_log_valid, r_overflow;
    logic             w_full, w_pop, w_push, w_drop;

    assign w_full       = (r_count == FULL_CNT);
    assign w_pop        = r_log_valid && log_ready && !clear;
    assign w_push       = w_fault && !clear && (!w_full || w_pop);
    assign w_drop       = w_fault && !clear && w_full && !w_pop;
    assign w_rd_next    = r_rd_ptr + PTR_W'(w_pop);
    assign w_after_pop  = r_count - (PTR_W + 1)'(w_pop);
    assign w_count_next = w_after_pop + (PTR_W + 1)'(w_push);

    // The head register bypasses the RAM when the incoming record becomes the new head.
    always_comb begin
        w_head_next = '0;
        if (w_count_next != '0) begin
            if (w_after_pop == '0) w_head_next = w_rec;
            else                   w_head_next = r_mem[w_rd_next];
        end
    end

    // NOTE: the log RAM has no reset; only pointers and count define which entries are live.
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr] <= w_rec;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_head      <= '0;
            r_log_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (clear) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_head      <= '0;
            r_log_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_rd_ptr    <= w_rd_next;
            r_wr_ptr    <= r_wr_ptr + PTR_W'(w_push);
            r_count     <= w_count_next;
            r_head      <= w_head_next;
            r_log_valid <= (w_count_next != '0);
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    logic [CNT_W-1:0] r_add_cnt, r_sll_cnt, r_sra_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_add_cnt <= '0;
            r_sll_cnt <= '0;
            r_sra_cnt <= '0;
        end else if (clear) begin
            r_add_cnt <= '0;
            r_sll_cnt <= '0;
            r_sra_cnt <= '0;
        end else if (r_s1_valid) begin
            if (r_s1_mask[0] && (r_add_cnt != '1)) r_add_cnt <= r_add_cnt + CNT_W'(1);
            if (r_s1_mask[1] && (r_sll_cnt != '1)) r_sll_cnt <= r_sll_cnt + CNT_W'(1);
            if (r_s1_mask[2] && (r_sra_cnt != '1)) r_sra_cnt <= r_sra_cnt + CNT_W'(1);
        end
    end

    state_t           r_state;
    logic [CON_W-1:0] r_consec, w_consec_next;
    logic             r_irq, r_disable;

    assign w_consec_next = (r_consec == LOCK_CNT) ? r_consec : r_consec + CON_W'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_OK;
            r_consec  <= '0;
            r_irq     <= 1'b0;
            r_disable <= 1'b0;
        end else if (clear) begin
            r_state   <= ST_OK;
            r_consec  <= '0;
            r_irq     <= 1'b0;
            r_disable <= 1'b0;
        end else if (r_s1_valid) begin
            r_consec <= w_fault ? w_consec_next : '0;
            case (r_state)
                ST_OK, ST_FAULT: begin
                    if (w_fault && (w_consec_next == LOCK_CNT)) begin
                        r_state   <= ST_LOCKED;
                        r_irq     <= 1'b1;
                        r_disable <= 1'b1;
                    end else if (w_fault) begin
                        r_state <= ST_FAULT;
                        r_irq   <= 1'b1;
                    end
                end
                ST_LOCKED: ;
                default: begin
                    r_state   <= ST_OK;
                    r_irq     <= 1'b0;
                    r_disable <= 1'b0;
                end
            endcase
        end
    end

    assign log_valid    = r_log_valid;
    assign log_mask     = r_head.mask;
    assign log_a        = r_head.a;
    assign log_result   = r_head.result;
    assign log_shamt    = r_head.shamt;
    assign log_overflow = r_overflow;
    assign add_err_cnt  = r_add_cnt;
    assign sll_err_cnt  = r_sll_cnt;
    assign sra_err_cnt  = r_sra_cnt;
    assign fault_irq    = r_irq;
    assign alu_disable  = r_disable;

endmodule
